// File: rtl/digit_to_int_pkg.sv
// Shared types and constants for the decimal entry accumulator
// and its conversion datapath.
package digit_to_int_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int ACC_W     = 14;
  localparam logic [3:0] DEC_MAX = 4'd9;

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    CONV  = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/digit_to_int_mul10_add.sv
// Combinational acc*10 + digit step for decimal-to-binary conversion.
// The x10 is two shifted adds so no multiplier is needed.
module mul10_add #(
  parameter int W = 14
) (
  input  logic [W-1:0] acc,
  input  logic [3:0]   digit,
  output logic [W-1:0] result
);

  assign result = (acc << 3) + (acc << 1) + W'(digit);

endmodule

// File: rtl/digit_to_int.sv
// Decimal entry accumulator: collects BCD digit strobes and a sign, then
// converts the entry to a signed two's-complement value on enter.
module digit_to_int
  import digit_to_int_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int WIDTH      = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  input  logic             neg_toggle,
  input  logic             enter,
  input  logic             clear,
  output logic             busy,
  output logic [3:0]       num3,
  output logic [3:0]       num2,
  output logic [3:0]       num1,
  output logic [3:0]       num0,
  output logic             sign,
  output logic [WIDTH-1:0] value,
  output logic             value_valid
);

  localparam logic [2:0] MAX_CNT = 3'(NUM_DIGITS);

  state_t             state, state_next;
  logic [2:0]         count;
  logic [1:0]         idx;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_next;
  logic [3:0]         digit_sel;
  logic [WIDTH-1:0]   mag;

  mul10_add #(.W(ACC_W)) u_mul10_add (
    .acc    (acc),
    .digit  (digit_sel),
    .result (acc_next)
  );

  assign busy = (state != ENTRY);
  assign mag  = WIDTH'(acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ENTRY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    digit_sel  = 4'd0;
    case (idx)
      2'd3:    digit_sel = num3;
      2'd2:    digit_sel = num2;
      2'd1:    digit_sel = num1;
      default: digit_sel = num0;
    endcase
    case (state)
      ENTRY: if (!clear && enter) state_next = CONV;
      CONV: begin
        if (clear)             state_next = ENTRY;
        else if (idx == 2'd0)  state_next = DONE;
      end
      DONE:    state_next = ENTRY;
      default: state_next = ENTRY;
    endcase
  end

  // Digits and sign stay frozen through CONV so the display shows what is being converted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num3        <= 4'd0;
      num2        <= 4'd0;
      num1        <= 4'd0;
      num0        <= 4'd0;
      sign        <= 1'b0;
      count       <= 3'd0;
      idx         <= 2'd0;
      acc         <= '0;
      value       <= '0;
      value_valid <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      case (state)
        ENTRY: begin
          if (clear) begin
            num3  <= 4'd0;
            num2  <= 4'd0;
            num1  <= 4'd0;
            num0  <= 4'd0;
            sign  <= 1'b0;
            count <= 3'd0;
          end else if (enter) begin
            acc <= '0;
            idx <= 2'd3;
          end else if (neg_toggle) begin
            sign <= ~sign;
          end else if (digit_valid && digit <= DEC_MAX && count < MAX_CNT) begin
            num3  <= num2;
            num2  <= num1;
            num1  <= num0;
            num0  <= digit;
            count <= count + 3'd1;
          end
        end
        CONV: begin
          if (clear) begin
            num3  <= 4'd0;
            num2  <= 4'd0;
            num1  <= 4'd0;
            num0  <= 4'd0;
            sign  <= 1'b0;
            count <= 3'd0;
          end else begin
            acc <= acc_next;
            idx <= idx - 2'd1;
          end
        end
        DONE: begin
          if (!clear) begin
            value       <= sign ? -mag : mag;
            value_valid <= 1'b1;
          end
          num3  <= 4'd0;
          num2  <= 4'd0;
          num1  <= 4'd0;
          num0  <= 4'd0;
          sign  <= 1'b0;
          count <= 3'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/digit_to_int.md
Name: digit_to_int

Overview:
- Sequential decimal entry accumulator: collects up to 4 BCD digit strobes plus a sign toggle, then converts them to a signed 16-bit two's-complement integer on `enter`.
- Inverse of the integer-to-digit display path; sits between keypad/UART digit decode and the arithmetic datapath.
- Live digit/sign outputs feed the existing seven-segment display driver unchanged.

Parameters:
- NUM_DIGITS, 4, maximum digits accepted (legal range 1..4).
- WIDTH, 16, width of signed result.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- digit_valid  input  1  one-cycle strobe; `digit` is valid this cycle.
- digit  input  4  BCD digit 0..9; values 10..15 are ignored.
- neg_toggle  input  1  one-cycle strobe; inverts the pending sign.
- enter  input  1  one-cycle strobe; starts conversion.
- clear  input  1  one-cycle strobe; discards entry or aborts conversion.
- busy  output  1  high during CONV and DONE; inputs other than `clear` are ignored.
- num3  output  4  display digit, thousands position.
- num2  output  4  display digit, hundreds position.
- num1  output  4  display digit, tens position.
- num0  output  4  display digit, units position (most recent digit entered).
- sign  output  1  pending sign, 1 = negative.
- value  output  WIDTH  signed result; held until the next completed conversion.
- value_valid  output  1  one-cycle pulse when `value` updates.

Behaviour:
- Reset (async, rst_n=0): state=ENTRY; num3..num0=0; sign=0; count=0; value=0; value_valid=0; busy=0.
- States: ENTRY, CONV, DONE.
- ENTRY, event priority clear > enter > neg_toggle > digit_valid; only the highest-priority strobe present in a cycle acts.
  - clear: digits, count and sign go to 0.
  - enter: go to CONV; acc=0; idx=3.
  - neg_toggle: sign = ~sign.
  - digit_valid with digit<=9 and count<NUM_DIGITS:
    - Shift left: num3<=num2, num2<=num1, num1<=num0, num0<=digit.
    - count++.
  - digit_valid with count==NUM_DIGITS: digit ignored (no shift, no wrap).
  - digit_valid with digit>9: ignored.
- CONV: one digit per cycle, idx 3→0.
  - acc <= acc*10 + num[idx].
  - The ×10 is built as (acc<<3)+(acc<<1), unsigned, 14 bits sufficient (max 9999).
  - After idx=0, go to DONE.
  - Always 4 cycles; unused leading positions are 0, so the result is unaffected.
- DONE: exactly one cycle.
  - value <= sign ? -acc : acc, sign-extended to WIDTH.
  - value_valid=1.
  - Digits, count and sign clear.
  - Return to ENTRY.
- Latency: enter accepted at edge T; value/value_valid visible after edge T+5; busy high from T+1 through T+5.
- Enter with count=0: result 0.
- Negative zero: sign=1 with magnitude 0 gives value=0 (0x0000), never 0x8000.
- Range: -9999..+9999; no overflow possible at WIDTH=16.
- clear during CONV/DONE:
  - Aborts; return to ENTRY.
  - Digits, count and sign clear.
  - No value_valid; value keeps its previous result.
- enter, neg_toggle and digit_valid while busy: dropped, no buffering.
- Async reset mid-conversion: immediate return to reset values, no value_valid.
- num3..num0 and sign remain stable during CONV, so the display shows the number being converted.

Decomposition:
- Shared package: WIDTH default, state encoding localparams (ENTRY, CONV, DONE), constant DEC_MAX=9.
- One natural sub-module: mul10_add, combinational acc*10+digit, reusable by other decimal paths.
- FSM and digit shift register stay in the top module.

Test Plan:
- Reset then digits 1,2,3,4, enter → num3..num0 = 1,2,3,4 before enter; value_valid pulses 5 cycles after enter with value=16'd1234 (0x04D2); busy high for those 5 cycles.
- Digits 5,0, neg_toggle, enter → sign=1 during entry; value=-50 (0xFFCE); afterwards sign=0, digits 0.
- Digits 9,9,9,9,7 (fifth over-length), neg_toggle, enter → 7 ignored; value=-9999 (0xD8F1).
- neg_toggle, enter with no digits → value=0x0000, value_valid pulses once.
- Digits 4,2, enter, clear 2 cycles later → no value_valid; value keeps prior result; state ENTRY; digits 0.
- Same-cycle enter+digit_valid(3) after digit 8 → enter wins, value=8; digit 12 strobe ignored; rst_n low mid-CONV → all outputs 0 asynchronously.
